sram_ctrl: RTL
==============

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: strobe-active cycles per SRAM access; legal range 1..15.
REQ-002 Clock is clk, single domain; reset is synchronous and active-high.
REQ-003 clk  input  1  100 MHz system clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 req_valid  input  1  byte request present.
REQ-006 req_ready  output  1  request accepted on clk edge when req_valid&&req_ready.
REQ-007 req_we  input  1  1=write, 0=read.
REQ-008 req_addr  input  20  byte address.
REQ-009 req_wdata  input  8  write byte.
REQ-010 rsp_valid  output  1  one-cycle completion pulse for read and write.
REQ-011 rsp_rdata  output  8  read byte, valid with rsp_valid; 8'h00 for writes.
REQ-012 ADR  output  19  SRAM word address.
REQ-013 DAT_OUT  output  16  SRAM write data.
REQ-014 DAT_IN  input  16  SRAM read data; the top-level tri-state pad drives it.
REQ-015 DAT_OE  output  1  1=drive DAT pads from DAT_OUT.
REQ-016 RAMCS, RAMOE, RAMWE  output  1 each  active-low SRAM strobes.

Function
REQ-017 States SHALL be IDLE, RD, TURN, WR_SETUP, WR_PULSE, WR_HOLD, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; requests are captured into internal registers on acceptance, and later input changes are ignored.
REQ-019 Read: IDLE->RD; RD holds RAMCS=0, RAMOE=0 for WAIT_CYCLES cycles; DAT_IN is sampled on the last RD edge; then ->RESP.
REQ-020 Write: WR_SETUP (1 cycle: RAMCS=0, DAT_OE=1, RAMWE=1) -> WR_PULSE (WAIT_CYCLES cycles, RAMWE=0) -> WR_HOLD (1 cycle, RAMWE=1, DAT_OE=1) -> RESP.
REQ-021 RESP SHALL last exactly 1 cycle with rsp_valid=1, then ->IDLE.
REQ-022 Read latency, accept edge to rsp_valid high: WAIT_CYCLES+1 cycles; write latency WAIT_CYCLES+3 (non-RMW) or 2*WAIT_CYCLES+4 (RMW).
REQ-023 ADR and DAT_OUT SHALL be stable from entry to RD/WR_SETUP through the last cycle before RESP.
REQ-024 DAT_OE SHALL never be 1 in any cycle where RAMOE=0; DAT_OE SHALL be 0 in IDLE, RD, TURN and RESP.
REQ-025 In IDLE and RESP: RAMCS=RAMOE=RAMWE=1, ADR holds its last value.
REQ-026 A wait counter SHALL count WAIT_CYCLES-1 down to 0 and reload on every state entry; the counter SHALL NOT wrap.
REQ-027 req_valid asserted in RESP SHALL be accepted in the following IDLE cycle; back-to-back throughput is one request per latency+1 cycles.

Reset
REQ-028 On reset, at the next edge: state=IDLE, RAMCS=RAMOE=RAMWE=1, DAT_OE=0, rsp_valid=0, rsp_rdata=0, ADR=0, DAT_OUT=0, req_ready=1 in the following cycle.
REQ-029 Reset mid-operation SHALL abort without a response; a write aborted in WR_PULSE leaves that SRAM word undefined.

Configuration
REQ-030 Macro SRAM_RMW_EN defined: ADR=req_addr[19:1], byte lane=req_addr[0] (0=low byte); read selects the addressed lane; write runs RD->TURN (1 cycle, all strobes high except RAMCS=0)->WR_SETUP with the captured word's addressed lane replaced by req_wdata.
REQ-031 SRAM_RMW_EN undefined: ADR=req_addr[18:0], req_addr[19] ignored; reads return DAT_IN[7:0]; writes skip RD/TURN and store {8'h00, req_wdata}.

Structure
REQ-032 Package sram_pkg SHALL hold the state enum, WAIT_CYCLES default and the width constants (20, 19, 16, 8).
REQ-033 Single module, no sub-module; the DAT tri-state pad stays in the chip top level.

Verification
REQ-034 Reset with req_valid=1 -> strobes all 1, DAT_OE=0, no rsp_valid for 3 cycles after release without request.
REQ-035 RMW, WAIT=2, preload word 0x00012=16'hAABB; read byte 0x00025 -> rsp_rdata=8'hAA exactly 3 cycles after accept.
REQ-036 RMW, write 8'h5C to byte 0x00024 over 16'hAABB -> DAT_OUT=16'hAA5C during WR_PULSE, rsp_valid 8 cycles after accept.
REQ-037 Non-RMW, write 8'h7E to 0x80003 -> ADR=19'h00003, DAT_OUT=16'h007E, RAMWE low exactly 2 cycles.
REQ-038 Back-to-back reads with req_valid held -> second accepted on the IDLE cycle after RESP; DAT_OE never 1 while RAMOE=0 (assertion).
REQ-039 Reset asserted in WR_PULSE -> next edge RAMWE=1, DAT_OE=0, no rsp_valid; subsequent read completes normally.

Source files
------------

// File: rtl/sram_pkg.sv
`timescale 1ns/1ps
// sram_pkg: state encoding, width constants and byte-lane helpers shared by
// the asynchronous-SRAM byte controller (sram_ctrl).
package sram_pkg;

    localparam int unsigned WAIT_DEFAULT = 2;   // strobe-active cycles per access
    localparam int unsigned REQ_ADDR_W   = 20;  // byte address width
    localparam int unsigned SRAM_ADR_W   = 19;  // SRAM word address width
    localparam int unsigned SRAM_DAT_W   = 16;  // SRAM data width
    localparam int unsigned BYTE_W       = 8;   // request data width
    localparam int unsigned CNT_W        = 4;   // wait counter width (WAIT_CYCLES <= 15)

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        TURN     = 3'd2,
        WR_SETUP = 3'd3,
        WR_PULSE = 3'd4,
        WR_HOLD  = 3'd5,
        RESP     = 3'd6
    } state_t;

    // Pick one byte lane out of a 16-bit SRAM word (lane 0 = low byte).
    function automatic logic [BYTE_W-1:0] lane_select(
        input logic [SRAM_DAT_W-1:0] word,
        input logic                  lane
    );
        logic [BYTE_W-1:0] b;
        if (lane) begin
            b = word[15:8];
        end else begin
            b = word[7:0];
        end
        return b;
    endfunction

    // Replace one byte lane of a 16-bit SRAM word, keeping the other lane.
    function automatic logic [SRAM_DAT_W-1:0] lane_merge(
        input logic [SRAM_DAT_W-1:0] word,
        input logic                  lane,
        input logic [BYTE_W-1:0]     data
    );
        logic [SRAM_DAT_W-1:0] w;
        w = word;
        if (lane) begin
            w[15:8] = data;
        end else begin
            w[7:0] = data;
        end
        return w;
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
`timescale 1ns/1ps
// sram_ctrl: byte-request front end for a 16-bit asynchronous SRAM.
// One request at a time; every strobe and response output is registered and
// decoded from the next state, so pins change only on clk edges.
// Build option: define SRAM_RMW_EN for byte-lane read-modify-write on the
// 16-bit array; without it each byte address maps to the low byte of one word.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [REQ_ADDR_W-1:0] req_addr,
    input  logic [BYTE_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [BYTE_W-1:0]     rsp_rdata,
    output logic [SRAM_ADR_W-1:0] ADR,
    output logic [SRAM_DAT_W-1:0] DAT_OUT,
    input  logic [SRAM_DAT_W-1:0] DAT_IN,
    output logic                  DAT_OE,
    output logic                  RAMCS,
    output logic                  RAMOE,
    output logic                  RAMWE
);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_we;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic [BYTE_W-1:0]     r_rsp_rdata;
    logic [SRAM_ADR_W-1:0] r_adr;
    logic [SRAM_DAT_W-1:0] r_dat_out;
    logic                  r_dat_oe;
    logic                  r_ramcs;
    logic                  r_ramoe;
    logic                  r_ramwe;

    state_t                w_state_nxt;
    logic                  w_cnt_done;
    logic                  w_accept;
    logic                  w_rd_last;
    logic                  w_cs_nxt;
    logic                  w_oe_nxt;
    logic                  w_we_nxt;
    logic                  w_doe_nxt;
    logic [BYTE_W-1:0]     w_rd_byte;
    logic [SRAM_ADR_W-1:0] w_req_adr;

`ifdef SRAM_RMW_EN
    logic                  r_lane;
    logic [BYTE_W-1:0]     r_wdata;

    assign w_req_adr = req_addr[REQ_ADDR_W-1:1];
    assign w_rd_byte = lane_select(DAT_IN, r_lane);
`else
    logic                  w_unused_addr_msb;

    assign w_req_adr         = req_addr[SRAM_ADR_W-1:0];
    assign w_rd_byte         = lane_select(DAT_IN, 1'b0);
    assign w_unused_addr_msb = req_addr[REQ_ADDR_W-1];
`endif

    assign w_cnt_done = (r_cnt == {CNT_W{1'b0}});
    assign w_accept   = (r_state == IDLE) && req_valid;
    assign w_rd_last  = (r_state == RD) && w_cnt_done;

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign ADR       = r_adr;
    assign DAT_OUT   = r_dat_out;
    assign DAT_OE    = r_dat_oe;
    assign RAMCS     = r_ramcs;
    assign RAMOE     = r_ramoe;
    assign RAMWE     = r_ramwe;

    // Next-state selection for the access sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
`ifdef SRAM_RMW_EN
                    w_state_nxt = RD;
`else
                    w_state_nxt = req_we ? WR_SETUP : RD;
`endif
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RD: begin
                if (w_cnt_done) begin
                    w_state_nxt = r_we ? TURN : RESP;
                end else begin
                    w_state_nxt = RD;
                end
            end
            TURN:     w_state_nxt = WR_SETUP;
            WR_SETUP: w_state_nxt = WR_PULSE;
            WR_PULSE: begin
                if (w_cnt_done) begin
                    w_state_nxt = WR_HOLD;
                end else begin
                    w_state_nxt = WR_PULSE;
                end
            end
            WR_HOLD:  w_state_nxt = RESP;
            RESP:     w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // Strobe pattern for the state being entered; data is only driven while RAMOE is high.
    always_comb begin
        w_cs_nxt  = 1'b1;
        w_oe_nxt  = 1'b1;
        w_we_nxt  = 1'b1;
        w_doe_nxt = 1'b0;
        case (w_state_nxt)
            RD: begin
                w_cs_nxt = 1'b0;
                w_oe_nxt = 1'b0;
            end
            TURN: begin
                w_cs_nxt = 1'b0;
            end
            WR_SETUP, WR_HOLD: begin
                w_cs_nxt  = 1'b0;
                w_doe_nxt = 1'b1;
            end
            WR_PULSE: begin
                w_cs_nxt  = 1'b0;
                w_we_nxt  = 1'b0;
                w_doe_nxt = 1'b1;
            end
            default: begin
                w_cs_nxt  = 1'b1;
                w_oe_nxt  = 1'b1;
                w_we_nxt  = 1'b1;
                w_doe_nxt = 1'b0;
            end
        endcase
    end

    // State register, wait counter and registered strobes/handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= CNT_RELOAD;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_ramcs     <= 1'b1;
            r_ramoe     <= 1'b1;
            r_ramwe     <= 1'b1;
            r_dat_oe    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == IDLE);
            r_rsp_valid <= (w_state_nxt == RESP);
            r_ramcs     <= w_cs_nxt;
            r_ramoe     <= w_oe_nxt;
            r_ramwe     <= w_we_nxt;
            r_dat_oe    <= w_doe_nxt;
            // Reload on any state change; saturate at zero otherwise.
            if (w_state_nxt != r_state) begin
                r_cnt <= CNT_RELOAD;
            end else if (!w_cnt_done) begin
                r_cnt <= r_cnt - CNT_ONE;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Request capture, SRAM address/write data and read-byte return path.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we        <= 1'b0;
            r_adr       <= {SRAM_ADR_W{1'b0}};
            r_dat_out   <= {SRAM_DAT_W{1'b0}};
            r_rsp_rdata <= {BYTE_W{1'b0}};
`ifdef SRAM_RMW_EN
            r_lane      <= 1'b0;
            r_wdata     <= {BYTE_W{1'b0}};
`endif
        end else begin
            if (w_accept) begin
                r_we  <= req_we;
                r_adr <= w_req_adr;
`ifdef SRAM_RMW_EN
                r_lane  <= req_addr[0];
                r_wdata <= req_wdata;
`else
                if (req_we) begin
                    r_dat_out <= {8'h00, req_wdata};
                end else begin
                    r_dat_out <= r_dat_out;
                end
`endif
            end else begin
                r_we  <= r_we;
                r_adr <= r_adr;
            end
`ifdef SRAM_RMW_EN
            // Merge the new byte into the word just read, before WR_SETUP is entered.
            if (w_rd_last && r_we) begin
                r_dat_out <= lane_merge(DAT_IN, r_lane, r_wdata);
            end else begin
                r_dat_out <= r_dat_out;
            end
`endif
            // Read byte is loaded on the edge entering RESP and cleared on the edge leaving it.
            if (w_rd_last && !r_we) begin
                r_rsp_rdata <= w_rd_byte;
            end else begin
                r_rsp_rdata <= {BYTE_W{1'b0}};
            end
        end
    end

endmodule
